// File: rtl/ram_sdp_memfile_if.sv
// Write, read and clear signal bundle for ram_sdp_memfile.
// parityErr is present only when RAM_SDP_PARITY_EN is defined.
interface ram_sdp_memfile_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 10
);
  logic                     wEn;
  logic [ADDRESS_WIDTH-1:0] wAddr;
  logic [DATA_WIDTH/8-1:0]  wByteEn;
  logic [DATA_WIDTH-1:0]    dataIn;
  logic                     rEn;
  logic [ADDRESS_WIDTH-1:0] rAddr;
  logic [DATA_WIDTH-1:0]    dataOut;
  logic                     rValid;
  logic                     clrReq;
  logic                     clrBusy;
`ifdef RAM_SDP_PARITY_EN
  logic                     parityErr;

  modport master (
    output wEn, wAddr, wByteEn, dataIn, rEn, rAddr, clrReq,
    input  dataOut, rValid, clrBusy, parityErr
  );
  modport slave (
    input  wEn, wAddr, wByteEn, dataIn, rEn, rAddr, clrReq,
    output dataOut, rValid, clrBusy, parityErr
  );
`else
  modport master (
    output wEn, wAddr, wByteEn, dataIn, rEn, rAddr, clrReq,
    input  dataOut, rValid, clrBusy
  );
  modport slave (
    input  wEn, wAddr, wByteEn, dataIn, rEn, rAddr, clrReq,
    output dataOut, rValid, clrBusy
  );
`endif
endinterface

// File: rtl/ram_sdp_memfile.sv
// Simple-dual-port RAM with byte enables, selectable read-during-write, optional
// output register and a clear sweeper. Define RAM_SDP_PARITY_EN for per-byte parity.
//
// state | meaning
// IDLE  | user reads and writes accepted
// CLEAR | writing CLEAR_VALUE to address cnt, user traffic ignored
module ram_sdp_memfile #(
  parameter int                    DATA_WIDTH    = 16,
  parameter int                    ADDRESS_WIDTH = 10,
  parameter int                    DEPTH         = 1024,
  parameter                        MEMFILE       = "",
  parameter int                    RDW_MODE      = 0,
  parameter int                    OUT_REG       = 0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE   = '0,
  parameter int                    INIT_CLEAR    = 0
) (
  input logic              clk,
  input logic              reset_n,
  ram_sdp_memfile_if.slave bus
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDRESS_WIDTH:0]   DEPTH_A = (ADDRESS_WIDTH+1)'(DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_A  = ADDRESS_WIDTH'(DEPTH - 1);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t                   state, state_nx;
  logic [ADDRESS_WIDTH-1:0] cnt, cnt_nx;
  logic                     init_pend;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic          idle, wr_ok, rd_ok, r_inr, rdw_hit;
  logic [IW-1:0] w_idx, r_idx, c_idx;
  logic [DATA_WIDTH-1:0] rd_word;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      init_pend <= (INIT_CLEAR != 0);
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      init_pend <= 1'b0;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (bus.clrReq || init_pend) state_nx = CLEAR;
      end
      CLEAR: begin
        if (cnt == LAST_A) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.clrBusy = (state == CLEAR);

  assign idle    = (state == IDLE);
  assign w_idx   = bus.wAddr[IW-1:0];
  assign r_idx   = bus.rAddr[IW-1:0];
  assign c_idx   = cnt[IW-1:0];
  assign wr_ok   = idle && bus.wEn && ({1'b0, bus.wAddr} < DEPTH_A);
  assign r_inr   = ({1'b0, bus.rAddr} < DEPTH_A);
  assign rd_ok   = idle && bus.rEn;
  assign rdw_hit = (RDW_MODE != 0) && wr_ok && (bus.wAddr == bus.rAddr);

  always_ff @(posedge clk) begin
    if (!idle) begin
      mem[c_idx] <= CLEAR_VALUE;
    end else if (wr_ok) begin
      for (int b = 0; b < NB; b++)
        if (bus.wByteEn[b]) mem[w_idx][8*b +: 8] <= bus.dataIn[8*b +: 8];
    end
  end

  // Out-of-range reads return zero; new-data mode merges the enabled write bytes.
  always_comb begin
    rd_word = '0;
    if (r_inr) begin
      rd_word = mem[r_idx];
      if (rdw_hit)
        for (int b = 0; b < NB; b++)
          if (bus.wByteEn[b]) rd_word[8*b +: 8] = bus.dataIn[8*b +: 8];
    end
  end

`ifdef RAM_SDP_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] pv_mem  [DEPTH];
  logic [NB-1:0] clr_par, wr_par, rd_bad;
  logic          rd_perr;

  // Byte valid bits start clear so preloaded words never report an error.
  initial begin
    for (int i = 0; i < DEPTH; i++) pv_mem[i] = '0;
  end

  always_comb begin
    for (int b = 0; b < NB; b++) begin
      clr_par[b] = ^CLEAR_VALUE[8*b +: 8];
      wr_par[b]  = ^bus.dataIn[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!idle) begin
      par_mem[c_idx] <= clr_par;
      pv_mem[c_idx]  <= '1;
    end else if (wr_ok) begin
      for (int b = 0; b < NB; b++)
        if (bus.wByteEn[b]) begin
          par_mem[w_idx][b] <= wr_par[b];
          pv_mem[w_idx][b]  <= 1'b1;
        end
    end
  end

  always_comb begin
    rd_bad = '0;
    if (r_inr) begin
      for (int b = 0; b < NB; b++) begin
        rd_bad[b] = pv_mem[r_idx][b] & ((^mem[r_idx][8*b +: 8]) ^ par_mem[r_idx][b]);
        if (rdw_hit && bus.wByteEn[b]) rd_bad[b] = 1'b0;
      end
    end
  end

  assign rd_perr = |rd_bad;
`endif

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] d1;
      logic                  v1;
`ifdef RAM_SDP_PARITY_EN
      logic                  p1;
`endif
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          d1          <= '0;
          v1          <= 1'b0;
          bus.dataOut <= '0;
          bus.rValid  <= 1'b0;
`ifdef RAM_SDP_PARITY_EN
          p1            <= 1'b0;
          bus.parityErr <= 1'b0;
`endif
        end else begin
          v1 <= rd_ok;
          if (rd_ok) d1 <= rd_word;
          bus.rValid <= v1;
          if (v1) bus.dataOut <= d1;
`ifdef RAM_SDP_PARITY_EN
          p1            <= rd_ok & rd_perr;
          bus.parityErr <= p1;
`endif
        end
      end
    end else begin : g_nreg
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          bus.dataOut <= '0;
          bus.rValid  <= 1'b0;
`ifdef RAM_SDP_PARITY_EN
          bus.parityErr <= 1'b0;
`endif
        end else begin
          bus.rValid <= rd_ok;
          if (rd_ok) bus.dataOut <= rd_word;
`ifdef RAM_SDP_PARITY_EN
          bus.parityErr <= rd_ok & rd_perr;
`endif
        end
      end
    end
  endgenerate
endmodule

// File: tb/tb_ram_sdp_memfile.sv
// Directed bench for ram_sdp_memfile: instance A (old-data, no output reg, 1024 words)
// and instance B (new-data, output reg, init clear, 16 words) share clock and reset.
module tb_ram_sdp_memfile;
  localparam int DW = 16;
  localparam int AW = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          sel;
  logic          w_en, r_en, clr_req;
  logic [AW-1:0] w_addr, r_addr;
  logic [1:0]    w_be;
  logic [DW-1:0] d_in;

  ram_sdp_memfile_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) if_a ();
  ram_sdp_memfile_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) if_b ();

  assign if_a.wEn     = w_en & ~sel;
  assign if_a.rEn     = r_en & ~sel;
  assign if_a.clrReq  = clr_req & ~sel;
  assign if_a.wAddr   = w_addr;
  assign if_a.rAddr   = r_addr;
  assign if_a.wByteEn = w_be;
  assign if_a.dataIn  = d_in;
  assign if_b.wEn     = w_en & sel;
  assign if_b.rEn     = r_en & sel;
  assign if_b.clrReq  = clr_req & sel;
  assign if_b.wAddr   = w_addr;
  assign if_b.rAddr   = r_addr;
  assign if_b.wByteEn = w_be;
  assign if_b.dataIn  = d_in;

  ram_sdp_memfile #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(1024), .MEMFILE(""),
    .RDW_MODE(0), .OUT_REG(0), .CLEAR_VALUE(16'h5A5A), .INIT_CLEAR(0)
  ) dut_a (.clk(clk), .reset_n(reset_n), .bus(if_a));

  ram_sdp_memfile #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(16), .MEMFILE(""),
    .RDW_MODE(1), .OUT_REG(1), .CLEAR_VALUE(16'h00C3), .INIT_CLEAR(1)
  ) dut_b (.clk(clk), .reset_n(reset_n), .bus(if_b));

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [1:0]    be;
    logic [DW-1:0] wd;
    logic          re;
    logic [AW-1:0] ra;
    logic [DW-1:0] exp_d;
    logic          exp_v;
  } vec_t;

  vec_t vt[$];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    w_en = 1'b0; r_en = 1'b0; clr_req = 1'b0;
    w_addr = '0; r_addr = '0; w_be = 2'b00; d_in = '0;
  endtask

  task automatic add(input logic we, input int wa, input logic [1:0] be, input logic [15:0] wd,
                     input logic re, input int ra, input logic [15:0] ed, input logic ev);
    vec_t v;
    v.we = we; v.wa = AW'(wa); v.be = be; v.wd = wd;
    v.re = re; v.ra = AW'(ra); v.exp_d = ed; v.exp_v = ev;
    vt.push_back(v);
  endtask

  task automatic wr(input int a, input logic [1:0] be, input logic [15:0] d);
    w_en = 1'b1; w_addr = AW'(a); w_be = be; d_in = d;
    tick();
    idle_in();
  endtask

  task automatic count_busy(input bit b_side, output int n);
    n = 0;
    for (int i = 0; i < 1200; i++) begin
      if ((b_side ? if_b.clrBusy : if_a.clrBusy) !== 1'b1) break;
      n++;
      tick();
    end
  endtask

  // Two-edge read on instance B.
  task automatic rd_b(input int a, output logic [15:0] d, output logic v, output logic p);
    r_en = 1'b1; r_addr = AW'(a);
    tick();
    idle_in();
    tick();
    d = if_b.dataOut; v = if_b.rValid;
`ifdef RAM_SDP_PARITY_EN
    p = if_b.parityErr;
`else
    p = 1'b0;
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, expected $finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, nv, nbad;
    logic [15:0] d;
    logic        v, p;
    int          ra_list[5];
    logic [15:0] re_list[5];

    sel = 1'b0;
    idle_in();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_dout",  if_a.dataOut, 16'h0);
    check("rst_a_valid", if_a.rValid,  1'b0);
    check("rst_a_busy",  if_a.clrBusy, 1'b0);
    check("rst_b_dout",  if_b.dataOut, 16'h0);
    check("rst_b_valid", if_b.rValid,  1'b0);
    reset_n = 1'b1;
    #1;
    check("rst_b_busy_pre_edge", if_b.clrBusy, 1'b0);
    tick();
    check("init_a_not_busy", if_a.clrBusy, 1'b0);
    count_busy(1'b1, n);
    check("init_b_busy_cycles", n, 16);

    // Instance A table: writes, reads, byte enables, read-during-write, ranges.
    add(1, 0,    2'b11, 16'h0000, 0, 0,    16'h0000, 0);
    add(1, 5,    2'b11, 16'h0005, 0, 0,    16'h0000, 0);
    add(1, 1023, 2'b11, 16'h03FF, 0, 0,    16'h0000, 0);
    add(1, 7,    2'b11, 16'h1234, 0, 0,    16'h0000, 0);
    add(1, 3,    2'b11, 16'h1111, 0, 0,    16'h0000, 0);
    add(0, 0,    2'b00, 16'h0000, 1, 0,    16'h0000, 1);
    add(0, 0,    2'b00, 16'h0000, 1, 5,    16'h0005, 1);
    add(0, 0,    2'b00, 16'h0000, 0, 0,    16'h0005, 0);
    add(0, 0,    2'b00, 16'h0000, 1, 1023, 16'h03FF, 1);
    add(1, 7,    2'b01, 16'hABCD, 0, 0,    16'h03FF, 0);
    add(0, 0,    2'b00, 16'h0000, 1, 7,    16'h12CD, 1);
    add(1, 3,    2'b11, 16'hBEEF, 1, 3,    16'h1111, 1);
    add(0, 0,    2'b00, 16'h0000, 1, 3,    16'hBEEF, 1);
    add(1, 1029, 2'b11, 16'hDEAD, 0, 0,    16'hBEEF, 0);
    add(0, 0,    2'b00, 16'h0000, 1, 5,    16'h0005, 1);
    add(0, 0,    2'b00, 16'h0000, 1, 1500, 16'h0000, 1);
    add(1, 0,    2'b00, 16'hFFFF, 0, 0,    16'h0000, 0);
    add(0, 0,    2'b00, 16'h0000, 1, 0,    16'h0000, 1);
    add(1, 5,    2'b11, 16'h7777, 1, 0,    16'h0000, 1);
    add(0, 0,    2'b00, 16'h0000, 1, 5,    16'h7777, 1);
    add(1, 3,    2'b10, 16'h55AA, 1, 3,    16'hBEEF, 1);
    add(0, 0,    2'b00, 16'h0000, 1, 3,    16'h55EF, 1);
    add(0, 0,    2'b00, 16'h0000, 1, 1024, 16'h0000, 1);

    foreach (vt[i]) begin
      w_en = vt[i].we; w_addr = vt[i].wa; w_be = vt[i].be; d_in = vt[i].wd;
      r_en = vt[i].re; r_addr = vt[i].ra;
      tick();
      check($sformatf("vec%0d_dout", i),   if_a.dataOut, vt[i].exp_d);
      check($sformatf("vec%0d_rvalid", i), if_a.rValid,  vt[i].exp_v);
    end
    idle_in();

    // Full clear sweep on A with traffic and a second request mid-sweep.
    r_en = 1'b1; r_addr = AW'(5);
    tick();
    idle_in();
    clr_req = 1'b1;
    tick();
    idle_in();
    n = 0; nv = 0;
    for (int i = 0; i < 1200; i++) begin
      if (if_a.clrBusy !== 1'b1) break;
      n++;
      if (if_a.rValid === 1'b1) nv++;
      if (i == 10) begin
        w_en = 1'b1; w_addr = AW'(1000); w_be = 2'b11; d_in = 16'h1111;
        r_en = 1'b1; r_addr = AW'(5); clr_req = 1'b1;
      end else begin
        idle_in();
      end
      tick();
    end
    idle_in();
    check("clr_busy_cycles", n, 1024);
    check("clr_no_rvalid",   nv, 0);
    check("clr_dout_hold",   if_a.dataOut, 16'h7777);
    nbad = 0;
    for (int a = 0; a < 1024; a++) begin
      r_en = 1'b1; r_addr = AW'(a);
      tick();
      if (if_a.dataOut !== 16'h5A5A || if_a.rValid !== 1'b1) nbad++;
    end
    idle_in();
    check("clr_all_words", nbad, 0);
    r_en = 1'b1; r_addr = AW'(1000);
    tick();
    idle_in();
    check("clr_write_dropped", if_a.dataOut, 16'h5A5A);

    // Reset 100 cycles into a sweep; the write issued with clrReq must land.
    wr(99,  2'b11, 16'h0099);
    wr(100, 2'b11, 16'h0100);
    wr(500, 2'b11, 16'h0500);
    clr_req = 1'b1; w_en = 1'b1; w_addr = AW'(900); w_be = 2'b11; d_in = 16'h0900;
    tick();
    idle_in();
    repeat (100) tick();
    check("abort_busy_before", if_a.clrBusy, 1'b1);
    reset_n = 1'b0;
    #1;
    check("abort_busy_async", if_a.clrBusy, 1'b0);
    check("abort_dout_zero",  if_a.dataOut, 16'h0);
    check("abort_rvalid",     if_a.rValid,  1'b0);
    #2 reset_n = 1'b1;
    tick();
    count_busy(1'b1, n);
    check("reinit_b_busy_cycles", n, 16);
    check("reinit_a_idle",        if_a.clrBusy, 1'b0);
    ra_list = '{0, 99, 100, 500, 900};
    re_list = '{16'h5A5A, 16'h5A5A, 16'h0100, 16'h0500, 16'h0900};
    for (int i = 0; i < 5; i++) begin
      r_en = 1'b1; r_addr = AW'(ra_list[i]);
      tick();
      check($sformatf("abort_rd_%0d", ra_list[i]), if_a.dataOut, re_list[i]);
    end
    idle_in();

    // Instance B: latency 2, new-data read-during-write, range, pipeline drain.
    sel = 1'b1;
    r_en = 1'b1; r_addr = AW'(8);
    tick();
    idle_in();
    check("b_lat_edge1_rvalid", if_b.rValid, 1'b0);
    tick();
    check("b_lat_edge2_rvalid", if_b.rValid, 1'b1);
    check("b_init_value",       if_b.dataOut, 16'h00C3);
    tick();
    check("b_rvalid_pulse",     if_b.rValid, 1'b0);
    check("b_dout_hold",        if_b.dataOut, 16'h00C3);

    wr(3, 2'b11, 16'h1111);
    w_en = 1'b1; w_addr = AW'(3); w_be = 2'b11; d_in = 16'hBEEF;
    r_en = 1'b1; r_addr = AW'(3);
    tick();
    idle_in();
    tick();
    check("b_rdw_new_full", if_b.dataOut, 16'hBEEF);

    wr(4, 2'b11, 16'h1234);
    w_en = 1'b1; w_addr = AW'(4); w_be = 2'b01; d_in = 16'hABCD;
    r_en = 1'b1; r_addr = AW'(4);
    tick();
    idle_in();
    tick();
    check("b_rdw_new_merge", if_b.dataOut, 16'h12CD);

    wr(20, 2'b11, 16'hDEAD);
    rd_b(4, d, v, p);
    check("b_oor_write_no_alias", d, 16'h12CD);

    rd_b(2000, d, v, p);
    check("b_oor_read_data",   d, 16'h0);
    check("b_oor_read_rvalid", v, 1'b1);
    check("b_oor_read_perr",   p, 1'b0);

`ifdef RAM_SDP_PARITY_EN
    wr(9, 2'b11, 16'h0F01);
    dut_b.par_mem[9] = dut_b.par_mem[9] ^ 2'b01;
    rd_b(9, d, v, p);
    check("b_par_data",   d, 16'h0F01);
    check("b_par_rvalid", v, 1'b1);
    check("b_par_err",    p, 1'b1);
    rd_b(8, d, v, p);
    check("b_par_clean",  p, 1'b0);
`endif

    r_en = 1'b1; r_addr = AW'(3);
    tick();
    idle_in();
    clr_req = 1'b1;
    tick();
    idle_in();
    check("b_drain_rvalid", if_b.rValid,  1'b1);
    check("b_drain_data",   if_b.dataOut, 16'hBEEF);
    check("b_drain_busy",   if_b.clrBusy, 1'b1);
    count_busy(1'b1, n);
    check("b_clr_busy_cycles", n, 16);
    rd_b(3, d, v, p);
    check("b_after_clear", d, 16'h00C3);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
